// File: rtl/sync_fifo_flags.sv
// Single-clock flop-array FIFO with occupancy count, programmable almost-full/almost-empty,
// optional first-word-fall-through read, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 56,
  parameter int AE_THRESH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   AF_LVL   = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_LVL   = (ADDR_WIDTH + 1)'(AE_THRESH);

  generate
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  // Flush wins over any same-cycle request, so nothing is accepted during it.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_wr    = wr_en & ~w_full & ~flush;
  assign w_rd    = rd_en & ~w_empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
      if (w_wr && !w_rd)      r_count <= r_count + CNT_ONE;
      else if (!w_wr && w_rd) r_count <= r_count - CNT_ONE;
    end
  end

  // A new violation in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr_en && w_full && !flush) r_ovf <= 1'b1;
      else if (clr_err)              r_ovf <= 1'b0;
      if (rd_en && w_empty && !flush) r_udf <= 1'b1;
      else if (clr_err)               r_udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = w_empty ? '0 : r_mem[r_rptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_dout <= '0;
        else if (w_rd) r_dout <= r_mem[r_rptr];
      end
      assign data_out = r_dout;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_LVL);
  assign almost_empty = (r_count <= AE_LVL);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
